// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch button sequencer.
package stopwatch_pkg;

    localparam int unsigned DEFAULT_COUNT_W = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_t;

    localparam logic [2:0] SSR_RUN   = 3'b100;
    localparam logic [2:0] SSR_HOLD  = 3'b010;
    localparam logic [2:0] SSR_CLEAR = 3'b001;

    // One-hot counter command for a given sequencer state.
    function automatic logic [2:0] ssr_of(input sw_state_t s);
        logic [2:0] r;
        r = SSR_CLEAR;
        case (s)
            IDLE:    r = SSR_CLEAR;
            RUN:     r = SSR_RUN;
            LAP:     r = SSR_RUN;
            PAUSE:   r = SSR_HOLD;
            default: r = SSR_CLEAR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Button front end: 2-flop synchronizer, optional debouncer, rising-edge pulse.
// Debounce stage is present only when STOPWATCH_CTRL_DEBOUNCE_EN is defined.
module sw_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic s1;
    logic s2;
    logic lvl;
    logic lvl_q;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             deb;

    // Accept a new level only after it has been seen DEBOUNCE_CYCLES times in a row.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (s2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            deb <= s2;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign lvl = deb;
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            lvl_q <= 1'b0;
            pulse <= 1'b0;
        end else begin
            lvl_q <= lvl;
            pulse <= lvl & ~lvl_q;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Pushbutton sequencer producing the run/hold/clear command, lap freeze and saturation pause.
// Optional debounce enabled with STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned COUNT_W         = DEFAULT_COUNT_W,
    parameter int unsigned MAX_COUNT       = 9999,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_ss,
    input  logic               btn_lap,
    input  logic [COUNT_W-1:0] count,
    output logic [2:0]         ssr,
    output logic [COUNT_W-1:0] disp,
    output logic               lap_valid,
    output logic [1:0]         state
);

    sw_state_t          cur;
    sw_state_t          nxt;
    logic               ss_p;
    logic               lap_p;
    logic               sat;
    logic [COUNT_W-1:0] lap_reg;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_ss),
        .pulse (ss_p)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_lap),
        .pulse (lap_p)
    );

    assign sat = (count >= COUNT_W'(MAX_COUNT));

    // Saturation beats both pulses; start/stop beats lap/clear.
    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE: begin
                if (ss_p) nxt = RUN;
            end
            RUN: begin
                if (sat || ss_p) nxt = PAUSE;
                else if (lap_p)  nxt = LAP;
            end
            LAP: begin
                if (sat || ss_p) nxt = PAUSE;
                else if (lap_p)  nxt = RUN;
            end
            PAUSE: begin
                if (ss_p)       nxt = sat ? PAUSE : RUN;
                else if (lap_p) nxt = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move together with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur       <= IDLE;
            ssr       <= SSR_CLEAR;
            disp      <= '0;
            lap_valid <= 1'b0;
            lap_reg   <= '0;
        end else begin
            cur       <= nxt;
            ssr       <= ssr_of(nxt);
            disp      <= (cur == LAP && nxt == LAP) ? lap_reg : count;
            lap_valid <= (nxt == LAP);
            if (cur == RUN && nxt == LAP) lap_reg <= count;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a queue scoreboard; follows STOPWATCH_CTRL_DEBOUNCE_EN.
module tb_stopwatch_ctrl;

    localparam int unsigned CW = 14;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int unsigned PL = 6;
`else
    localparam int unsigned PL = 3;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_LAP   = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_ss;
    logic          btn_lap;
    logic [CW-1:0] count;
    logic [2:0]    ssr;
    logic [CW-1:0] disp;
    logic          lap_valid;
    logic [1:0]    state;

    stopwatch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .btn_ss    (btn_ss),
        .btn_lap   (btn_lap),
        .count     (count),
        .ssr       (ssr),
        .disp      (disp),
        .lap_valid (lap_valid),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [2:0]    ssr;
        logic [1:0]    st;
        logic [CW-1:0] disp;
        logic          lv;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            passed = 0;
    int            fails  = 0;
    logic          auto_inc = 1'b0;
    logic [CW-1:0] prev_count;

    function automatic logic [2:0] exp_ssr(input logic [1:0] s);
        if (s == S_IDLE)  return 3'b001;
        if (s == S_PAUSE) return 3'b010;
        return 3'b100;
    endfunction

    task automatic tick();
        @(posedge clk);
        prev_count = count;
        #1;
        if (auto_inc) count = count + CW'(1);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic [CW-1:0] d);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.ssr  = exp_ssr(st);
        e.disp = d;
        e.lv   = (st == S_LAP);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert ({ssr, state, disp, lap_valid} === {e.ssr, e.st, e.disp, e.lv}) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: got ssr=%b state=%0d disp=%0d lap_valid=%b, expected ssr=%b state=%0d disp=%0d lap_valid=%b",
                   e.tag, ssr, state, disp, lap_valid, e.ssr, e.st, e.disp, e.lv);
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] st, input logic [CW-1:0] d);
        expect_out(tag, st, d);
        check_out();
    endtask

    // Raise the given buttons and advance until the pulse is registered but not yet acted on.
    task automatic press(input logic ss, input logic lap);
        btn_ss  = ss;
        btn_lap = lap;
        repeat (PL) tick();
    endtask

    task automatic release_btns();
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        repeat (PL + 2) tick();
    endtask

    initial begin
        rst     = 1'b0;
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        count   = '0;
        tick();
        tick();
        chk("reset", S_IDLE, CW'(0));
        rst = 1'b1;

        // start: hold 10 cycles, exactly one transition
        press(1'b1, 1'b0);
        chk("start_pre", S_IDLE, prev_count);
        tick();
        chk("start", S_RUN, prev_count);
        repeat (10 - PL - 1) tick();
        chk("start_held", S_RUN, prev_count);
        release_btns();
        chk("start_released", S_RUN, prev_count);

        press(1'b1, 1'b0);
        chk("stop_pre", S_RUN, prev_count);
        tick();
        chk("stop", S_PAUSE, prev_count);
        release_btns();

        press(1'b1, 1'b0);
        tick();
        chk("resume", S_RUN, prev_count);
        release_btns();

        // lap freeze while the counter keeps moving
        count = CW'(1234);
        press(1'b0, 1'b1);
        tick();
        chk("lap_enter", S_LAP, CW'(1234));
        auto_inc = 1'b1;
        release_btns();
        chk("lap_freeze", S_LAP, CW'(1234));
        press(1'b0, 1'b1);
        chk("lap_pre_release", S_LAP, CW'(1234));
        tick();
        chk("lap_release", S_RUN, prev_count);
        release_btns();
        chk("lap_tracking", S_RUN, prev_count);
        auto_inc = 1'b0;

        // clear from PAUSE, lap ignored in IDLE
        press(1'b1, 1'b0);
        tick();
        chk("stop2", S_PAUSE, prev_count);
        release_btns();
        press(1'b0, 1'b1);
        tick();
        chk("clear", S_IDLE, prev_count);
        release_btns();
        press(1'b0, 1'b1);
        tick();
        chk("idle_lap_ignored", S_IDLE, prev_count);
        release_btns();

        // saturation boundary
        press(1'b1, 1'b0);
        tick();
        chk("start3", S_RUN, prev_count);
        release_btns();
        count = CW'(9998);
        tick();
        chk("below_max", S_RUN, CW'(9998));
        count = CW'(9999);
        tick();
        chk("saturate", S_PAUSE, CW'(9999));
        press(1'b1, 1'b0);
        tick();
        chk("ss_at_max", S_PAUSE, CW'(9999));
        release_btns();
        count = CW'(16000);
        tick();
        chk("above_max_passthru", S_PAUSE, CW'(16000));

        // simultaneous presses in PAUSE: start/stop wins
        count = CW'(100);
        press(1'b1, 1'b1);
        tick();
        chk("simul_pause", S_RUN, CW'(100));
        release_btns();

        // 2-cycle glitch on start/stop
        btn_ss = 1'b1;
        tick();
        tick();
        btn_ss = 1'b0;
        repeat (10) tick();
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
        chk("glitch_filtered", S_RUN, CW'(100));
        release_btns();
`else
        chk("glitch_pulse", S_PAUSE, CW'(100));
        press(1'b1, 1'b0);
        tick();
        chk("rerun", S_RUN, CW'(100));
        release_btns();
`endif

        // reset with a pulse pending drops it
        press(1'b1, 1'b0);
        rst    = 1'b0;
        btn_ss = 1'b0;
        tick();
        chk("mid_reset", S_IDLE, CW'(0));
        rst = 1'b1;
        repeat (PL + 2) tick();
        chk("pulse_dropped", S_IDLE, CW'(100));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven sequencer for the 14-bit stopwatch counter. Converts two raw pushbuttons, start/stop and lap/clear, into the level-coded 3-bit start/stop/reset command the counter consumes. Adds lap (split) capture with display freeze and saturation at the display limit. Sits between the board pushbuttons and the stopwatch counter; its `disp` output feeds the 4-digit display decoder.

## Interface
- `COUNT_W`, 14: counter and display width.
- `MAX_COUNT`, 9999: largest displayable count; reaching it forces a pause.
- `DEBOUNCE_CYCLES`, 3: stable-input cycles required to accept a button change (30 ms at the 100 Hz stopwatch clock).

- `clk` in 1: stopwatch clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `btn_ss` in 1: raw start/stop button, asynchronous, active-high.
- `btn_lap` in 1: raw lap/clear button, asynchronous, active-high.
- `count` in COUNT_W: current value from the stopwatch counter.
- `ssr` out 3: command to the counter.
  - 3'b100 = run.
  - 3'b010 = hold.
  - 3'b001 = clear.
- `disp` out COUNT_W: value to display.
- `lap_valid` out 1: high while `disp` shows a frozen lap value.
- `state` out 2: encoded FSM state, for LEDs.

## Operation
- Input path per button:
  - 2-flop synchronizer.
  - Debouncer (see Configuration).
  - Rising-edge detector producing a 1-cycle pulse: `ss_p` from `btn_ss`, `lap_p` from `btn_lap`.
- FSM states and `state` encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- IDLE transitions:
  - `ss_p` → RUN.
  - `lap_p` is ignored.
- RUN transitions:
  - `ss_p` → PAUSE.
  - `lap_p` → LAP and `lap_reg <= count`.
  - `count >= MAX_COUNT` → PAUSE.
- LAP transitions:
  - `lap_p` → RUN (display released).
  - `ss_p` → PAUSE (display released).
  - `count >= MAX_COUNT` → PAUSE.
- PAUSE transitions:
  - `ss_p` → RUN, unless `count >= MAX_COUNT`, in which case it stays in PAUSE.
  - `lap_p` → IDLE.
- Simultaneous events:
  - `ss_p` and `lap_p` in the same cycle: `ss_p` wins and `lap_p` is discarded.
  - Saturation has priority over both pulses.
- `ssr` is decoded from the state register and registered:
  - IDLE → 3'b001.
  - RUN and LAP → 3'b100.
  - PAUSE → 3'b010.
  - Exactly one bit is set at all times.
- `disp` (registered):
  - LAP: `lap_reg`.
  - All other states: `count`.
- `lap_valid` is 1 only in LAP.
- Holding a button produces exactly one pulse; a new press requires a release first.
- Values of `count` above MAX_COUNT are passed to `disp` unchanged; no clamping is done here.

## Timing
- Reset values, applied on the first edge with `rst`=0:
  - State IDLE.
  - `ssr`=3'b001.
  - `disp`=0.
  - `lap_valid`=0.
  - `lap_reg`=0.
  - Synchronizer, debounce and edge registers cleared (button treated as released).
- Reset mid-operation (any state) returns to IDLE on that edge and drops any pending pulse.
- Button-to-pulse latency:
  - With debounce: 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) cycles.
  - Without debounce: 3 cycles.
- Pulse-to-output: state, `ssr`, `lap_valid` and `disp` update on the edge after the pulse cycle (1-cycle latency).
- `disp` lags `count` by 1 cycle outside LAP.
- Saturation: the cycle `count` first equals MAX_COUNT, the next edge enters PAUSE and `ssr`=3'b010. The counter may advance by at most 1 further count.

## Configuration
- `STOPWATCH_CTRL_DEBOUNCE_EN` defined:
  - Each synchronized input must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes.
  - Any bounce restarts the count.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Undefined:
  - The debouncer is removed and the synchronizer output feeds the edge detector directly.
  - DEBOUNCE_CYCLES is ignored.

## Structure
- Package `stopwatch_pkg`:
  - State enum `sw_state_t` (IDLE/RUN/PAUSE/LAP).
  - SSR constants `SSR_RUN`=3'b100, `SSR_HOLD`=3'b010, `SSR_CLEAR`=3'b001.
  - Default `COUNT_W`.
- Sub-module `sw_debounce`:
  - Contains synchronizer, optional debounce counter and edge detector.
  - Instantiated twice, once per button.
  - All macro-dependent logic lives here.

## Test plan
- Reset: `rst`=0 for 2 cycles → `ssr`=3'b001, `disp`=0, `state`=0, `lap_valid`=0.
- Start, then stop:
  - `btn_ss` held high 10 cycles → `ssr`=3'b100 exactly 2+3+1+1=7 cycles after the rise; one transition only.
  - Second press → `ssr`=3'b010.
- Lap freeze:
  - In RUN with `count`=1234, press `btn_lap` → `disp` holds 1234 and `lap_valid`=1 while `count` keeps rising.
  - Second lap press → `disp` tracks `count` again.
- Clear: in PAUSE, press `btn_lap` → `ssr`=3'b001, `state`=0. In IDLE, pressing `btn_lap` leaves the state unchanged.
- Saturation and conflict:
  - Drive `count`=9999 in RUN → PAUSE next cycle.
  - `ss_p` while `count`=9999 stays in PAUSE.
  - Simultaneous `ss_p`/`lap_p` in PAUSE → RUN.
- Bounce:
  - With the macro defined, a 2-cycle glitch on `btn_ss` → no state change.
  - Without the macro → a pulse 3 cycles after the rise.
